adc_cfg_seq: RTL and testbench

Register-configuration sequencer that sits directly upstream of the ADC SPI command engine. After reset, or on a `start` pulse, it walks a fixed table of ADC register writes. For each table entry it:
- issues a single-register write through the `cmd_write`/`cmd_write_ack` handshake;
- optionally reads the register back and compares it against the written value;
- retries a mismatch a bounded number of times.

It reports `cfg_done` or `cfg_error` to the acquisition control logic.

---
 rtl/adc_cfg_seq_pkg.sv | 50 +++++
 rtl/adc_cfg_rom.sv | 23 ++
 rtl/adc_cfg_seq.sv | 197 +++++++++++++++++++
 tb/tb_adc_cfg_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cfg_seq_pkg.sv
// Shared definitions for the ADC configuration sequencer: FSM states,
// ROM entry field layout, fixed register values and the design table.
package adc_cfg_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WR    = 3'd2,
        S_RD    = 3'd3,
        S_CHECK = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam int ENT_W        = 22;
    localparam int ENT_VERIFY   = 21;
    localparam int ENT_ADDR_LSB = 8;
    localparam int ENT_DATA_LSB = 0;

    localparam logic [12:0] SOFTRST_ADDR = 13'h000;
    localparam logic [7:0]  SOFTRST_DATA = 8'h3C;
    localparam logic [12:0] XFER_ADDR    = 13'h0FF;
    localparam logic [7:0]  XFER_DATA    = 8'h01;

    function automatic logic [ENT_W-1:0] mk_entry(input logic verify,
                                                  input logic [12:0] addr,
                                                  input logic [7:0] data);
        logic [ENT_W-1:0] e;
        e                         = '0;
        e[ENT_VERIFY]             = verify;
        e[ENT_ADDR_LSB +: 13]     = addr;
        e[ENT_DATA_LSB +: 8]      = data;
        return e;
    endfunction

    // Body of the table, between the soft reset and the transfer entries.
    function automatic logic [ENT_W-1:0] design_entry(input int i);
        case (i)
            0:       return mk_entry(1'b1, 13'h014, 8'h01);
            1:       return mk_entry(1'b1, 13'h015, 8'h02);
            2:       return mk_entry(1'b1, 13'h016, 8'h00);
            3:       return mk_entry(1'b1, 13'h018, 8'h0F);
            4:       return mk_entry(1'b1, 13'h020, 8'h4F);
            5:       return mk_entry(1'b1, 13'h021, 8'h80);
            default: return mk_entry(1'b1, 13'h100 + 13'(i), 8'(i));
        endcase
    endfunction

endpackage

// File: rtl/adc_cfg_rom.sv
// Combinational register table: soft reset first, transfer last, design
// values in between. Replace this file to change the table.
module adc_cfg_rom
    import adc_cfg_seq_pkg::*;
#(
    parameter int NUM_REGS = 8,
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [IW-1:0]    i_idx,
    output logic [ENT_W-1:0] o_entry
);

    always_comb begin
        if (i_idx == '0) begin
            o_entry = mk_entry(1'b0, SOFTRST_ADDR, SOFTRST_DATA);
        end else if (i_idx == IW'(NUM_REGS - 1)) begin
            o_entry = mk_entry(1'b0, XFER_ADDR, XFER_DATA);
        end else begin
            o_entry = design_entry(int'(i_idx) - 1);
        end
    end

endmodule

// File: rtl/adc_cfg_seq.sv
// Walks the ADC register table through the SPI command engine with optional
// readback verify, bounded retries and a per-transaction ack watchdog.
module adc_cfg_seq
    import adc_cfg_seq_pkg::*;
#(
    parameter int NUM_REGS       = 8,
    parameter int POWERUP_CYCLES = 100000,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        cmd_write,
    output logic        cmd_read,
    input  logic        cmd_write_ack,
    input  logic        cmd_read_ack,
    output logic [12:0] write_addr,
    output logic [7:0]  write_data,
    output logic [12:0] read_addr,
    input  logic [7:0]  read_data,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [5:0]  err_index
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic [RW-1:0]   r_retry, w_retry_nxt;
    logic [PW-1:0]   r_dly, w_dly_nxt;
    logic [TW-1:0]   r_wdog, w_wdog_nxt;
    logic [5:0]      r_err_index, w_err_idx_nxt;
    logic            r_cmd_write, r_cmd_read, r_verify;
    logic [12:0]     r_write_addr, r_read_addr;
    logic [7:0]      r_write_data, r_rd_data;
    logic            r_busy, r_cfg_done, r_cfg_error;
    logic            w_done_nxt, w_error_nxt, w_busy_nxt, w_timeout;
    logic [ENT_W-1:0] w_entry;

    // Indexed by the next index so the request registers load with the state.
    adc_cfg_rom #(.NUM_REGS(NUM_REGS)) u_rom (
        .i_idx   (w_idx_nxt),
        .o_entry (w_entry)
    );

    assign w_timeout = (r_wdog == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_retry_nxt   = r_retry;
        w_dly_nxt     = r_dly;
        w_wdog_nxt    = r_wdog + 1'b1;
        w_err_idx_nxt = r_err_index;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        w_busy_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_dly_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_dly == PW'(POWERUP_CYCLES - 1)) begin
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = S_WR;
                end else begin
                    w_dly_nxt = r_dly + 1'b1;
                end
            end
            S_WR: begin
                if (cmd_write_ack) begin
                    w_state_nxt = r_verify ? S_RD : S_NEXT;
                end else if (w_timeout) begin
                    w_err_idx_nxt = 6'(r_idx);
                    w_state_nxt   = S_ERR;
                end
            end
            S_RD: begin
                if (cmd_read_ack) begin
                    w_state_nxt = S_CHECK;
                end else if (w_timeout) begin
                    w_err_idx_nxt = 6'(r_idx);
                    w_state_nxt   = S_ERR;
                end
            end
            S_CHECK: begin
                if (r_rd_data == r_write_data) begin
                    w_state_nxt = S_NEXT;
                end else if (r_retry < RW'(MAX_RETRY)) begin
                    w_retry_nxt = r_retry + 1'b1;
                    w_state_nxt = S_WR;
                end else begin
                    w_err_idx_nxt = 6'(r_idx);
                    w_state_nxt   = S_ERR;
                end
            end
            S_NEXT: begin
                if (r_idx == IW'(NUM_REGS - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_retry_nxt = '0;
                    w_state_nxt = S_WR;
                end
            end
            // A start in the first terminal cycle is dropped: the flag is not yet up.
            S_DONE: begin
                if (start && r_cfg_done) begin
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = S_WR;
                end else begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end
            end
            S_ERR: begin
                if (start && r_cfg_error) begin
                    w_idx_nxt     = '0;
                    w_retry_nxt   = '0;
                    w_err_idx_nxt = '0;
                    w_state_nxt   = S_WR;
                end else begin
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != r_state) begin
            w_wdog_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_retry      <= '0;
            r_dly        <= '0;
            r_wdog       <= '0;
            r_err_index  <= '0;
            r_cmd_write  <= 1'b0;
            r_cmd_read   <= 1'b0;
            r_verify     <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_read_addr  <= '0;
            r_rd_data    <= '0;
            r_busy       <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_cfg_error  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_retry     <= w_retry_nxt;
            r_dly       <= w_dly_nxt;
            r_wdog      <= w_wdog_nxt;
            r_err_index <= w_err_idx_nxt;
            r_cmd_write <= (w_state_nxt == S_WR);
            r_cmd_read  <= (w_state_nxt == S_RD);
            r_busy      <= w_busy_nxt;
            r_cfg_done  <= w_done_nxt;
            r_cfg_error <= w_error_nxt;
            if (w_state_nxt == S_WR && r_state != S_WR) begin
                r_verify     <= w_entry[ENT_VERIFY];
                r_write_addr <= w_entry[ENT_ADDR_LSB +: 13];
                r_write_data <= w_entry[ENT_DATA_LSB +: 8];
            end
            if (w_state_nxt == S_RD && r_state != S_RD) begin
                r_read_addr <= r_write_addr;
            end
            if (r_state == S_RD && cmd_read_ack) begin
                r_rd_data <= read_data;
            end
        end
    end

    assign cmd_write  = r_cmd_write;
    assign cmd_read   = r_cmd_read;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign read_addr  = r_read_addr;
    assign busy       = r_busy;
    assign cfg_done   = r_cfg_done;
    assign cfg_error  = r_cfg_error;
    assign err_index  = r_err_index;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// Bench for adc_cfg_seq: SPI engine model with programmable ack latency and
// readback faults, table of whole-run scenarios plus hand-timed corner cases.
module tb_adc_cfg_seq;

    logic        clk, rst_n, start;
    logic        cmd_write, cmd_read, cmd_write_ack, cmd_read_ack;
    logic [12:0] write_addr, read_addr;
    logic [7:0]  write_data, read_data;
    logic        busy, cfg_done, cfg_error;
    logic [5:0]  err_index;

    adc_cfg_seq #(
        .NUM_REGS(3), .POWERUP_CYCLES(16), .MAX_RETRY(3), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_write_ack(cmd_write_ack), .cmd_read_ack(cmd_read_ack),
        .write_addr(write_addr), .write_data(write_data),
        .read_addr(read_addr), .read_data(read_data),
        .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .err_index(err_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         lat = 5;
    int         bad_left = 0;
    int         viol = 0;
    int         cnt = 0;
    string      tx_log = "";
    logic [7:0] last_wdata = 8'h00;

    // SPI engine model: acks after lat request cycles (0 = never), both acks together.
    initial begin
        cmd_write_ack = 1'b0;
        cmd_read_ack  = 1'b0;
        read_data     = 8'h00;
        forever begin
            @(negedge clk);
            cmd_write_ack = 1'b0;
            cmd_read_ack  = 1'b0;
            if (cmd_write && cmd_read) viol++;
            if (cmd_write || cmd_read) begin
                cnt++;
                if (lat > 0 && cnt == lat) begin
                    cnt = 0;
                    cmd_write_ack = 1'b1;
                    cmd_read_ack  = 1'b1;
                    if (cmd_read) begin
                        if (bad_left > 0) begin
                            read_data = 8'h00;
                            bad_left--;
                        end else begin
                            read_data = last_wdata;
                        end
                        tx_log = {tx_log, $sformatf(" R%h:%h", read_addr[11:0], read_data)};
                    end else begin
                        last_wdata = write_data;
                        tx_log = {tx_log, $sformatf(" W%h:%h", write_addr[11:0], write_data)};
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Count cycles from reset release to the first write request: 1 IDLE + 16 WAIT.
    task automatic powerup_check(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 1) chk({name, "_busy_rise"}, busy, 1'b1);
            if (cmd_write) break;
        end
        chk({name, "_first_wr"}, n, 17);
    endtask

    typedef struct {
        int    lat;
        int    bad;
        string exp_log;
        bit    exp_done;
        bit    exp_err;
        int    exp_idx;
    } vec_t;

    vec_t  vecs[6];
    string w0, w1, w2, rb, rg, full;

    task automatic run_vec(input int i);
        int n;
        lat      = vecs[i].lat;
        bad_left = vecs[i].bad;
        do_reset();
        tx_log = "";
        n = 0;
        while (!(cfg_done || cfg_error) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk($sformatf("v%0d_finish", i), 1'b0, 1'b1);
        repeat (5) tick();
        chk_s($sformatf("v%0d_log", i), tx_log, vecs[i].exp_log);
        chk($sformatf("v%0d_done", i), cfg_done, vecs[i].exp_done);
        chk($sformatf("v%0d_err", i), cfg_error, vecs[i].exp_err);
        chk($sformatf("v%0d_idx", i), err_index, vecs[i].exp_idx);
        chk($sformatf("v%0d_busy", i), busy, 1'b0);
    endtask

    initial begin
        int n;
        w0 = " W000:3c"; w1 = " W014:01"; w2 = " W0ff:01";
        rb = " R014:00"; rg = " R014:01";
        full = {w0, w1, rg, w2};
        vecs[0] = '{5,    0,    full,                                     1'b1, 1'b0, 0};
        vecs[1] = '{3,    2,    {w0, w1, rb, w1, rb, w1, rg, w2},         1'b1, 1'b0, 0};
        vecs[2] = '{2,    1000, {w0, w1, rb, w1, rb, w1, rb, w1, rb},     1'b0, 1'b1, 1};
        vecs[3] = '{49,   0,    full,                                     1'b1, 1'b0, 0};
        vecs[4] = '{0,    0,    "",                                       1'b0, 1'b1, 0};
        vecs[5] = '{1,    3,    {w0, w1, rb, w1, rb, w1, rb, w1, rg, w2}, 1'b1, 1'b0, 0};

        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk("reset_outputs",
            {cmd_write, cmd_read, busy, cfg_done, cfg_error, err_index,
             write_addr, write_data, read_addr}, '0);

        rst_n = 1'b1;
        powerup_check("powerup");
        chk("first_wr_addr", write_addr, 13'h000);
        chk("first_wr_data", write_data, 8'h3C);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Watchdog: request held exactly 50 cycles, error flag one cycle after S_ERR.
        lat = 0;
        do_reset();
        n = 0;
        while (!cmd_write && n < 100) begin tick(); n++; end
        n = 0;
        while (cmd_write && n < 200) begin tick(); n++; end
        chk("timeout_wr_cycles", n, 50);
        chk("timeout_err_lag", {cfg_error, busy}, 2'b01);
        tick();
        chk("timeout_err_rise", {cfg_error, busy, err_index}, {1'b1, 1'b0, 6'd0});

        // Reset while a read is outstanding.
        lat = 10;
        bad_left = 0;
        do_reset();
        n = 0;
        while (!cmd_read && n < 500) begin tick(); n++; end
        chk("rd_seen_before_reset", cmd_read, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rd_dropped_by_reset", {cmd_read, cmd_write, busy}, 3'b000);
        rst_n = 1'b1;
        powerup_check("rst_restart");

        // Restart from S_DONE, then starts that must be ignored.
        lat = 5;
        bad_left = 0;
        run_vec(0);
        tx_log = "";
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_flags", {cfg_done, busy, cmd_write}, 3'b011);
        chk("restart_entry0", {write_addr, write_data}, {13'h000, 8'h3C});
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (tx_log != full && n < 500) begin tick(); n++; end
        chk_s("busy_start_ignored", tx_log, full);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_rise", {cfg_done, busy}, 2'b10);
        tick();
        tick();
        chk("coincident_start_ignored", {cmd_write, cfg_done, busy}, 3'b010);

        chk("cmd_exclusive", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
